// File: rtl/rca_output_wb_sequencer.sv
// In-order writeback sequencer for RCA grid output IO blocks running in FIFO mode.
// Optional watchdog enabled by defining RCA_WB_TIMEOUT_EN.
module rca_output_wb_sequencer #(
  parameter int unsigned NUM_IO         = 4,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ID_W           = 3,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       issue_valid,
  output logic                                       issue_ready,
  input  logic [((NUM_IO > 1) ? $clog2(NUM_IO) : 1)-1:0] issue_sel,
  input  logic [ID_W-1:0]                            issue_id,
  input  logic [4:0]                                 issue_rd,
  input  logic [NUM_IO-1:0]                          io_valid,
  input  logic [NUM_IO*XLEN-1:0]                     io_data,
  output logic [NUM_IO-1:0]                          io_pop,
  output logic                                       io_fifo_rst,
  input  logic                                       flush,
  output logic                                       wb_valid,
  output logic [ID_W-1:0]                            wb_id,
  output logic [4:0]                                 wb_rd,
  output logic [XLEN-1:0]                            wb_data,
  input  logic                                       wb_ack,
  output logic                                       busy,
  output logic                                       err_timeout
);

  localparam int unsigned SEL_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0] q_sel_q [DEPTH];
  logic [ID_W-1:0]  q_id_q  [DEPTH];
  logic [4:0]       q_rd_q  [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            wb_valid_q, wb_valid_d;
  logic [ID_W-1:0] wb_id_q, wb_id_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            io_fifo_rst_q, io_fifo_rst_d;

  logic            empty;
  logic            full;
  logic            enq;
  logic            to_hit;
  logic [SEL_W-1:0] head_sel;
  logic [ID_W-1:0] head_id;
  logic [4:0]      head_rd;
  logic            head_valid;
  logic [XLEN-1:0] head_data;

`ifdef RCA_WB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign issue_ready = !full && (state_q != S_FLUSH);
  assign busy        = !empty || (state_q != S_IDLE);

  assign head_sel = q_sel_q[rd_ptr_q[AW-1:0]];
  assign head_id  = q_id_q[rd_ptr_q[AW-1:0]];
  assign head_rd  = q_rd_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    head_valid = 1'b0;
    head_data  = '0;
    for (int unsigned k = 0; k < NUM_IO; k++) begin
      if (head_sel == SEL_W'(k)) begin
        head_valid = io_valid[k];
        head_data  = io_data[k*XLEN +: XLEN];
      end
    end
  end

  // A watchdog expiry behaves like an internal flush, so it also blocks enqueue.
  always_comb begin
    to_hit = 1'b0;
`ifdef RCA_WB_TIMEOUT_EN
    to_hit = (state_q == S_WAIT) && !head_valid && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif
  end

  assign enq = issue_valid && issue_ready && !flush && !to_hit;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q + PW'(enq);
    rd_ptr_d      = rd_ptr_q;
    wb_valid_d    = wb_valid_q;
    wb_id_d       = wb_id_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    io_fifo_rst_d = 1'b0;
    io_pop        = '0;
`ifdef RCA_WB_TIMEOUT_EN
    cnt_d         = '0;
    err_d         = err_q;
`endif
    if (flush || to_hit) begin
      state_d       = S_FLUSH;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      wb_valid_d    = 1'b0;
      io_fifo_rst_d = 1'b1;
`ifdef RCA_WB_TIMEOUT_EN
      if (to_hit) err_d = 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (head_valid) begin
            wb_valid_d = 1'b1;
            wb_id_d    = head_id;
            wb_rd_d    = head_rd;
            wb_data_d  = head_data;
            state_d    = S_PRESENT;
          end
`ifdef RCA_WB_TIMEOUT_EN
          else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        S_PRESENT: begin
          if (wb_ack) begin
            io_pop     = NUM_IO'(1) << head_sel;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            wb_valid_d = 1'b0;
            state_d    = (wr_ptr_d != rd_ptr_d) ? S_WAIT : S_IDLE;
          end
        end
        S_FLUSH: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_id_q       <= '0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      io_fifo_rst_q <= 1'b0;
`ifdef RCA_WB_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_id_q       <= wb_id_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      io_fifo_rst_q <= io_fifo_rst_d;
`ifdef RCA_WB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
    if (enq) begin
      q_sel_q[wr_ptr_q[AW-1:0]] <= issue_sel;
      q_id_q[wr_ptr_q[AW-1:0]]  <= issue_id;
      q_rd_q[wr_ptr_q[AW-1:0]]  <= issue_rd;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_id       = wb_id_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign io_fifo_rst = io_fifo_rst_q;
`ifdef RCA_WB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rca_output_wb_sequencer.sv
// Directed vector bench for rca_output_wb_sequencer (watchdog check only when RCA_WB_TIMEOUT_EN is defined).
module tb_rca_output_wb_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic [1:0]   issue_sel;
  logic [2:0]   issue_id;
  logic [4:0]   issue_rd;
  logic [3:0]   io_valid;
  logic [127:0] io_data;
  logic [3:0]   io_pop;
  logic         io_fifo_rst;
  logic         flush;
  logic         wb_valid;
  logic [2:0]   wb_id;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         wb_ack;
  logic         busy;
  logic         err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_output_wb_sequencer #(
    .NUM_IO(4), .XLEN(32), .ID_W(3), .DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_sel(issue_sel), .issue_id(issue_id), .issue_rd(issue_rd),
    .io_valid(io_valid), .io_data(io_data), .io_pop(io_pop), .io_fifo_rst(io_fifo_rst),
    .flush(flush), .wb_valid(wb_valid), .wb_id(wb_id), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ack(wb_ack), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic         iv;
    logic [1:0]   sel;
    logic [2:0]   id;
    logic [4:0]   rd;
    logic [3:0]   vld;
    logic [127:0] dat;
    logic         ack;
    logic         fl;
    logic         e_wbv;
    logic [2:0]   e_id;
    logic [4:0]   e_rd;
    logic [31:0]  e_data;
    logic [3:0]   e_pop;
    logic         e_rdy;
    logic         e_busy;
    logic         e_frst;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] D1 = 128'h00000000_DEADBEEF_00000000_00000000;
  localparam logic [127:0] DA = 128'h44444444_33333333_22222222_11111111;

  function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic [2:0] id,
                              input logic [4:0] rd, input logic [3:0] vld, input logic [127:0] dat,
                              input logic ack, input logic fl, input logic e_wbv, input logic [2:0] e_id,
                              input logic [4:0] e_rd, input logic [31:0] e_data, input logic [3:0] e_pop,
                              input logic e_rdy, input logic e_busy, input logic e_frst);
    vec_t v;
    v.iv = iv; v.sel = sel; v.id = id; v.rd = rd; v.vld = vld; v.dat = dat; v.ack = ack; v.fl = fl;
    v.e_wbv = e_wbv; v.e_id = e_id; v.e_rd = e_rd; v.e_data = e_data; v.e_pop = e_pop;
    v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_frst = e_frst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_sel = '0; issue_id = '0; issue_rd = '0;
    io_valid = '0; wb_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_wbv"},  32'(wb_valid), 32'd0);
    chk({tag, "_id"},   32'(wb_id), 32'd0);
    chk({tag, "_rd"},   32'(wb_rd), 32'd0);
    chk({tag, "_data"}, wb_data, 32'd0);
    chk({tag, "_pop"},  32'(io_pop), 32'd0);
    chk({tag, "_frst"}, 32'(io_fifo_rst), 32'd0);
    chk({tag, "_err"},  32'(err_timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Scenario: single result from unit 2.
    vecs.push_back(mk(1,2,3,10,4'b0000,D1,0,0, 0,0,0,0,4'b0000,1,0,0));
    vecs.push_back(mk(0,0,0, 0,4'b0000,D1,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0100,D1,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0000,D1,1,0, 1,3,10,32'hDEADBEEF,4'b0100,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0000,D1,0,0, 0,0,0,0,4'b0000,1,0,0));
    // Scenario: in-order writeback while unit 1 is ready first.
    vecs.push_back(mk(1,0,1,1,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));
    vecs.push_back(mk(1,1,2,2,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0010,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0010,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0011,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0011,DA,1,0, 1,1,1,32'h11111111,4'b0001,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0010,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0010,DA,1,0, 1,2,2,32'h22222222,4'b0010,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));
    // Scenario: fill the queue, 5th issue refused, drain in order.
    vecs.push_back(mk(1,0,0,20,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));
    vecs.push_back(mk(1,0,1,21,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(1,0,2,22,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(1,0,3,23,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(1,0,4,24,4'b0000,DA,0,0, 0,0,0,0,4'b0000,0,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,0,0, 0,0,0,0,4'b0000,0,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,1,0, 1,0,20,32'h11111111,4'b0001,0,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,1,0, 1,1,21,32'h11111111,4'b0001,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,1,0, 1,2,22,32'h11111111,4'b0001,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0001,DA,1,0, 1,3,23,32'h11111111,4'b0001,1,1,0));
    vecs.push_back(mk(0,0,0, 0,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));
    // Scenario: flush beats ack in PRESENT, then back-to-back flush.
    vecs.push_back(mk(1,1,6,9,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0010,DA,0,0, 0,0,0,0,4'b0000,1,1,0));
    vecs.push_back(mk(0,0,0,0,4'b0010,DA,1,1, 1,6,9,32'h22222222,4'b0000,1,1,0));
    vecs.push_back(mk(1,0,7,1,4'b0000,DA,0,0, 0,0,0,0,4'b0000,0,1,1));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,1, 0,0,0,0,4'b0000,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,1, 0,0,0,0,4'b0000,0,1,1));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,0, 0,0,0,0,4'b0000,0,1,1));
    vecs.push_back(mk(0,0,0,0,4'b0000,DA,0,0, 0,0,0,0,4'b0000,1,0,0));

    io_data = '0;
    do_reset();
    #1;
    check_idle_zero("reset");
    chk("reset_ready", 32'(issue_ready), 32'd1);

    foreach (vecs[i]) begin
      issue_valid = vecs[i].iv;  issue_sel = vecs[i].sel;
      issue_id    = vecs[i].id;  issue_rd  = vecs[i].rd;
      io_valid    = vecs[i].vld; io_data   = vecs[i].dat;
      wb_ack      = vecs[i].ack; flush     = vecs[i].fl;
      #1;
      chk($sformatf("r%0d_wbv", i),   32'(wb_valid),    32'(vecs[i].e_wbv));
      chk($sformatf("r%0d_pop", i),   32'(io_pop),      32'(vecs[i].e_pop));
      chk($sformatf("r%0d_rdy", i),   32'(issue_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("r%0d_busy", i),  32'(busy),        32'(vecs[i].e_busy));
      chk($sformatf("r%0d_frst", i),  32'(io_fifo_rst), 32'(vecs[i].e_frst));
      if (vecs[i].e_wbv) begin
        chk($sformatf("r%0d_id", i),   32'(wb_id),   32'(vecs[i].e_id));
        chk($sformatf("r%0d_rd", i),   32'(wb_rd),   32'(vecs[i].e_rd));
        chk($sformatf("r%0d_data", i), wb_data,      vecs[i].e_data);
      end
      tick();
    end

    // Stall: result held for 10 cycles without ack.
    idle_inputs();
    io_data = DA;
    issue_valid = 1'b1; issue_sel = 2'd3; issue_id = 3'd5; issue_rd = 5'd7;
    tick();
    idle_inputs();
    tick();
    io_valid = 4'b1000;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d_wbv", c),  32'(wb_valid), 32'd1);
      chk($sformatf("stall%0d_data", c), wb_data, 32'h44444444);
      chk($sformatf("stall%0d_id", c),   32'(wb_id), 32'd5);
      chk($sformatf("stall%0d_pop", c),  32'(io_pop), 32'd0);
      tick();
    end
    wb_ack = 1'b1;
    #1;
    chk("stall_ack_pop", 32'(io_pop), 32'b1000);
    tick();
    idle_inputs();
    #1;
    chk("stall_after_wbv", 32'(wb_valid), 32'd0);
    chk("stall_after_busy", 32'(busy), 32'd0);

    // Reset in the middle of a presented result drops everything.
    issue_valid = 1'b1; issue_sel = 2'd0; issue_id = 3'd2; issue_rd = 5'd3;
    tick();
    idle_inputs();
    tick();
    io_valid = 4'b0001;
    tick();
    chk("midrst_pre_wbv", 32'(wb_valid), 32'd1);
    do_reset();
    #1;
    check_idle_zero("midrst");

`ifdef RCA_WB_TIMEOUT_EN
    begin
      int n;
      idle_inputs();
      issue_valid = 1'b1; issue_sel = 2'd0; issue_id = 3'd1; issue_rd = 5'd1;
      tick();
      idle_inputs();
      tick();
      n = 0;
      while (!err_timeout && n < 100) begin
        tick();
        n++;
      end
      chk("to_cycles", 32'(n), 32'd16);
      chk("to_frst", 32'(io_fifo_rst), 32'd1);
      tick();
      chk("to_frst_end", 32'(io_fifo_rst), 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
      for (int c = 0; c < 5; c++) tick();
      chk("to_sticky", 32'(err_timeout), 32'd1);
      do_reset();
      #1;
      chk("to_cleared", 32'(err_timeout), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
